pixel_frame_feeder: RTL

Upstream image-ingest stage for the CNN top level. Accepts a byte stream (valid/ready), pairs bytes into 16-bit signed pixels, buffers them in a small FIFO and drives the network's image_pixel/store load interface. After the full frame is stored and store_finish returns, it pulses start. It then waits for one_end before accepting the next frame.

---
 rtl/pixel_frame_feeder_if.sv | 23 ++
 rtl/pixel_frame_feeder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pixel_frame_feeder_if.sv
// Purpose: byte-ingest and network-load signal bundle for pixel_frame_feeder.
// Ports: rx_byte/rx_valid/rx_ready byte stream in; image_pixel/store pixel load out;
//        store_finish/start/one_end frame handshake with the network.
interface pixel_frame_feeder_if;
  logic        [7:0]  rx_byte;
  logic               rx_valid;
  logic               rx_ready;
  logic signed [15:0] image_pixel;
  logic               store;
  logic               store_finish;
  logic               start;
  logic               one_end;

  // master: the feeder itself; slave: the byte source plus the network
  modport master (
    input  rx_byte, rx_valid, store_finish, one_end,
    output rx_ready, image_pixel, store, start
  );
  modport slave (
    output rx_byte, rx_valid, store_finish, one_end,
    input  rx_ready, image_pixel, store, start
  );
endinterface

// File: rtl/pixel_frame_feeder.sv
// Purpose: pair bytes into signed pixels, buffer them and load one frame into the network.
// Latency: high byte accepted at edge N (FIFO empty) -> store=1 with that pixel after edge N+1.
// Backpressure: rx_ready drops when the FIFO is full, the frame is fully accepted, or outside IDLE/LOAD.
// Ports: clk, n_reset (sync, active-low); bus = pixel_frame_feeder_if.master;
//        busy (state != IDLE), frame_cnt (completed frames), err_sync (sticky early store_finish).

// Small generic synchronous FIFO; caller never pushes when full nor pops when empty.
module fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [NW-1:0]    count;

  assign out_dat = mem[rd_ptr];
  assign full    = (count == NW'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (in_vld) mem[wr_ptr] <= in_dat;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally
      if (in_vld)  wr_ptr <= wr_ptr + AW'(1);
      if (out_rdy) rd_ptr <= rd_ptr + AW'(1);
      case ({in_vld, out_rdy})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module pixel_frame_feeder #(
  parameter int FRAME_PIXELS = 784,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                clk,
  input  logic                n_reset,
  pixel_frame_feeder_if.master bus,
  output logic                busy,
  output logic [15:0]         frame_cnt,
  output logic                err_sync
);
  localparam int CW = $clog2(FRAME_PIXELS + 1);
  localparam logic [CW-1:0] FP_C = CW'(FRAME_PIXELS);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_STORE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] acc_cnt;    // pixels assembled this frame
  logic [CW-1:0] st_cnt;     // pixels stored into the network this frame
  logic          phase_hi;   // next byte is the high byte
  logic [7:0]    lo_reg;
  logic          fifo_full, fifo_empty;
  logic [15:0]   fifo_dat;
  logic          rx_fire, push, pop;
  logic          start_nxt, frame_done;

  // Held low while n_reset is asserted so the source sees no acceptance during reset.
  assign bus.rx_ready = n_reset && (state == IDLE || state == LOAD) &&
                        !fifo_full && (acc_cnt < FP_C);
  assign rx_fire = bus.rx_valid && bus.rx_ready;
  assign push    = rx_fire && phase_hi;
  assign pop     = (state == LOAD) && !fifo_empty;
  assign busy    = (state != IDLE);

  fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .in_vld  (push),
    .in_dat  ({bus.rx_byte, lo_reg}),
    .out_rdy (pop),
    .out_dat (fifo_dat),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_nxt  = state;
    start_nxt  = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:       if (rx_fire) state_nxt = LOAD;
      LOAD:       if (st_cnt == FP_C) state_nxt = WAIT_STORE;
      WAIT_STORE: if (bus.store_finish) begin
                    start_nxt = 1'b1;
                    state_nxt = RUN;
                  end
      RUN:        if (bus.one_end) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                  end
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state           <= IDLE;
      bus.store       <= 1'b0;
      bus.image_pixel <= '0;
      bus.start       <= 1'b0;
      frame_cnt       <= '0;
      err_sync        <= 1'b0;
      acc_cnt         <= '0;
      st_cnt          <= '0;
      phase_hi        <= 1'b0;
      lo_reg          <= '0;
    end else begin
      state     <= state_nxt;
      bus.start <= start_nxt;
      bus.store <= pop;
      if (pop) begin
        bus.image_pixel <= fifo_dat;
        st_cnt          <= st_cnt + CW'(1);
      end
      if (rx_fire) begin
        if (phase_hi) begin
          phase_hi <= 1'b0;
          acc_cnt  <= acc_cnt + CW'(1);
        end else begin
          lo_reg   <= bus.rx_byte;
          phase_hi <= 1'b1;
        end
      end
      // Only reachable from RUN, so it never races the byte/pop updates above.
      if (frame_done) begin
        frame_cnt <= frame_cnt + 16'd1;
        acc_cnt   <= '0;
        st_cnt    <= '0;
        phase_hi  <= 1'b0;
      end
      // All stores complete before WAIT_STORE is entered, so an early finish
      // can only be seen in IDLE or LOAD.
      if (bus.store_finish && (state == IDLE || state == LOAD)) err_sync <= 1'b1;
    end
  end
endmodule
